// File: rtl/median_window_ctrl.sv
// -----------------------------------------------------------------------------
// median_window_ctrl
//
// Streaming front end for an external 9-input median sorter. Raster pixels are
// written into two line buffers while a 3x3 window slides across the image.
// The window is presented on w0..w8. The sorter's combinational result comes
// back on median_in and is registered into a valid/ready output stage. Only
// interior pixels are emitted, (IMG_H-2)*(IMG_W-2) per frame, and out_last
// marks the final one.
//
// Optional build macro: MEDIAN_BYPASS_EN
//   Adds a 'bypass' input. When bypass is high, the output stage captures the
//   window centre (w4) instead of median_in. bypass is sampled when the window
//   moves into the output stage.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_pix/in_valid      raster-order input pixel stream
//   in_ready             pixel accepted when in_valid && in_ready
//   w0..w8               window to median9: w0..w2 row r-2, w3..w5 row r-1,
//                        w6..w8 row r, left to right (w4 is the centre)
//   median_in            median9 result, combinational from w0..w8
//   out_pix/out_valid    filtered pixel stream
//   out_ready            sink accepts out_pix
//   out_last             out_pix is the last filtered pixel of the frame
//   busy                 a frame is in progress
//   bypass               (MEDIAN_BYPASS_EN only) pass the centre pixel through
// -----------------------------------------------------------------------------
module median_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_pix,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic [7:0] w7,
    output logic [7:0] w8,
    input  logic [7:0] median_in,
`ifdef MEDIAN_BYPASS_EN
    input  logic       bypass,
`endif
    output logic [7:0] out_pix,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);
    localparam int DATA_W = 8;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb0 [IMG_W];   // line r-1
    logic [DATA_W-1:0] lb1 [IMG_W];   // line r-2
    logic [DATA_W-1:0] win_p1 [9];
    logic              vld_p1;
    logic              last_p1;
    logic              s2_free;
    logic              s1_move;
    logic              in_acc;
    logic              out_acc;
    logic              at_end;
    logic [DATA_W-1:0] s2_pix;

    assign s2_free  = !out_valid || out_ready;
    assign s1_move  = vld_p1 && s2_free;
    assign in_ready = (state == IDLE || state == RUN) && (!vld_p1 || s2_free);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign at_end   = (row == ROW_LAST) && (col == COL_LAST);
    assign busy     = (state != IDLE);

    assign w0 = win_p1[0];
    assign w1 = win_p1[1];
    assign w2 = win_p1[2];
    assign w3 = win_p1[3];
    assign w4 = win_p1[4];
    assign w5 = win_p1[5];
    assign w6 = win_p1[6];
    assign w7 = win_p1[7];
    assign w8 = win_p1[8];

`ifdef MEDIAN_BYPASS_EN
    assign s2_pix = bypass ? win_p1[4] : median_in;
`else
    assign s2_pix = median_in;
`endif

    // Raster position and frame state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            if (in_acc) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                IDLE:    if (in_acc) state <= RUN;
                RUN:     if (in_acc && at_end) state <= DRAIN;
                DRAIN:   if (out_acc && out_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffers: pure storage, contents are irrelevant after reset
    always_ff @(posedge clk) begin
        if (in_acc) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pix;
        end
    end

    // ---- S1: window registers ----
    // The window only shifts on an input accept, and an accept with a full
    // window requires the output stage to be free, so a valid window is never
    // overwritten before it has moved on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) win_p1[i] <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (in_acc) begin
            win_p1[0] <= win_p1[1];
            win_p1[1] <= win_p1[2];
            win_p1[2] <= lb1[col];
            win_p1[3] <= win_p1[4];
            win_p1[4] <= win_p1[5];
            win_p1[5] <= lb0[col];
            win_p1[6] <= win_p1[7];
            win_p1[7] <= win_p1[8];
            win_p1[8] <= in_pix;
            vld_p1    <= (row >= RW'(2)) && (col >= CW'(2));
            // Bottom-right pixel of the frame puts the centre at (IMG_H-2, IMG_W-2)
            last_p1   <= at_end;
        end else if (s1_move) begin
            vld_p1 <= 1'b0;
        end
    end

    // ---- S2: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pix   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (s1_move) begin
            out_pix   <= s2_pix;
            out_valid <= 1'b1;
            out_last  <= last_p1;
        end else if (s2_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_window_ctrl
//
// Bench for median_window_ctrl on a 4x4 image. A behavioural median9 closes
// the loop on w0..w8. Expected outputs come from a frame-level reference:
// each whole frame is stored, and the median (or centre, in bypass) of every
// interior 3x3 neighbourhood is queued. A per-cycle monitor models pipeline
// occupancy, frame state and latency to predict in_ready, busy and output
// timing. The monitor also checks that output is held stable while stalled.
// -----------------------------------------------------------------------------
module tb_median_window_ctrl;
    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_pix = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic [7:0] median_in;
    logic [7:0] out_pix;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
`ifdef MEDIAN_BYPASS_EN
    logic       bypass = 1'b0;
`endif

    median_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .w4        (w4),
        .w5        (w5),
        .w6        (w6),
        .w7        (w7),
        .w8        (w8),
        .median_in (median_in),
`ifdef MEDIAN_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] med9(input logic [71:0] v);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = v[8*i +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    // Stand-in for the external median9 instance
    assign median_in = med9({w0, w1, w2, w3, w4, w5, w6, w7, w8});

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] frame [H][W];
    logic [7:0] exp_pix_q [$];
    bit         exp_last_q [$];
    int         lat_q [$];
    int         pend = 0;
    int         cyc = 0;
    int         mr = 0;
    int         mc = 0;
    bit         drain = 0;
    bit         busy_exp = 0;
    bit         lat_chk = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_pix = '0;
    bit         prev_last = 0;
    int         rdy_mode = 0;

    // kind: 0 ramp 16*r+c, 1 impulse (10 with 255 at (1,1)), 2 random
    task automatic build_frame(input int kind, input bit byp);
        logic [71:0] nb;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       frame[r][c] = 8'(16 * r + c);
                    1:       frame[r][c] = (r == 1 && c == 1) ? 8'd255 : 8'd10;
                    default: frame[r][c] = 8'($urandom);
                endcase
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        nb[8*(dr*3+dc) +: 8] = frame[r+dr-1][c+dc-1];
                exp_pix_q.push_back(byp ? frame[r][c] : med9(nb));
                exp_last_q.push_back(r == H - 2 && c == W - 2);
            end
    endtask

    // Drives the first npix pixels of 'frame'; entered and left at posedge+1
    task automatic drive_frame(input int npix, input bit gaps);
        bit got;
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_pix   = frame[i / W][i % W];
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk); #1;
            end
            if (!got) chk("in_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_pix_q.size() == 0 && !busy) break;
            @(posedge clk); #1;
        end
        chk("drain_timeout", 32'(k < 300), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_pix", 32'(out_pix), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_w4", 32'(w4), 32'd0);
        exp_pix_q.delete();
        exp_last_q.delete();
        lat_q.delete();
        pend = 0; drain = 0; busy_exp = 0; prev_stall = 0; mr = 0; mc = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle monitor: the handshakes seen here complete at the next posedge
    always @(negedge clk) begin : mon
        bit ia, oa, prod, exp_rdy, e_last;
        int lt;
        if (rst_n) begin
            cyc++;
            ia = in_valid && in_ready;
            oa = out_valid && out_ready;
            exp_rdy = !drain && !(pend == 2 && !out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(busy_exp));
            if (pend == 0) chk("empty_out_valid", 32'(out_valid), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_pix", 32'(out_pix), 32'(prev_pix));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (oa) begin
                if (exp_pix_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_pix), 32'hFFFF_FFFF);
                end else begin
                    chk("out_pix", 32'(out_pix), 32'(exp_pix_q.pop_front()));
                    e_last = exp_last_q.pop_front();
                    chk("out_last", 32'(out_last), 32'(e_last));
                    if (lat_q.size() > 0) begin
                        lt = lat_q.pop_front();
                        if (lat_chk) chk("latency", 32'(cyc), 32'(lt));
                    end
                    if (e_last) begin drain = 0; busy_exp = 0; end
                end
            end
            prod = 0;
            if (ia) begin
                prod = (mr >= 2 && mc >= 2);
                if (prod) lat_q.push_back(cyc + 2);
                busy_exp = 1;
                if (mr == H - 1 && mc == W - 1) drain = 1;
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
            pend = pend + int'(prod) - int'(oa);
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pix;
            prev_last  = out_last;
        end
    end

    // out_ready patterns: 0 always ready, 1 one on / two off, 2 random
    initial begin : rdy_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_pix", 32'(out_pix), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_window", 32'(|{w0, w1, w2, w3, w4, w5, w6, w7, w8}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ramp, no backpressure: 17, 18, 33, 34 with two-cycle latency
        rdy_mode = 0; lat_chk = 1;
        build_frame(0, 0); drive_frame(W * H, 0); wait_done();

        // Impulse removed
        build_frame(1, 0); drive_frame(W * H, 0); wait_done();

        // Ramp under periodic backpressure with input gaps
        rdy_mode = 1; lat_chk = 0;
        build_frame(0, 0); drive_frame(W * H, 1); wait_done();

        // Abort after 7 pixels, then a clean frame
        rdy_mode = 0; lat_chk = 1;
        build_frame(0, 0); drive_frame(7, 0); pulse_reset();
        build_frame(0, 0); drive_frame(W * H, 0); wait_done();

        // Back-to-back frames: second must wait out the drain
        build_frame(2, 0); drive_frame(W * H, 0);
        build_frame(0, 0); drive_frame(W * H, 0); wait_done();

        // Random data, random backpressure, random gaps
        rdy_mode = 2; lat_chk = 0;
        repeat (4) begin
            build_frame(2, 0); drive_frame(W * H, 1);
        end
        wait_done();

`ifdef MEDIAN_BYPASS_EN
        // Centre pass-through: 255, 10, 10, 10
        rdy_mode = 0; lat_chk = 1;
        bypass = 1'b1;
        build_frame(1, 1); drive_frame(W * H, 0); wait_done();
        rdy_mode = 2; lat_chk = 0;
        build_frame(2, 1); drive_frame(W * H, 1); wait_done();
        bypass = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
- Streaming controller that feeds the 9-input median sorter.
- Accepts a raster pixel stream and buffers two image lines. It builds a sliding 3x3 window, drives the window to an external median9 instance and captures that instance's result.
- Emits filtered interior pixels, (IMG_H-2)*(IMG_W-2) per frame, with valid/ready flow control.
- Sits between the pixel source (frame reader) and the output writer in the filter pipeline.

Parameters:
- IMG_W, 64, pixels per line; must be >= 3.
- IMG_H, 64, lines per frame; must be >= 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_pix  in  8  input pixel, raster order.
- in_valid  in  1  in_pix valid.
- in_ready  out  1  controller can accept in_pix this cycle.
- w0..w8  out  8 each  window to median9: w0..w2 = row r-2, w3..w5 = row r-1, w6..w8 = row r; left to right; w4 is centre.
- median_in  in  8  median9 result (combinational from w0..w8).
- out_pix  out  8  filtered pixel.
- out_valid  out  1  out_pix valid.
- out_ready  in  1  sink accepts out_pix.
- out_last  out  1  qualifies out_pix as the last pixel of the frame.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - out_pix=0, out_valid=0, out_last=0, busy=0, w0..w8=0.
  - in_ready=1.
  - col=0, row=0, state=IDLE.
  - Line-buffer contents are don't-care.
- An input accept is in_valid && in_ready; an output accept is out_valid && out_ready.
- Pipeline stages:
  - S1: window registers plus win_valid.
  - S2: output register (out_pix, out_valid, out_last).
- Stall and accept rules:
  - s2_free = !out_valid || out_ready.
  - in_ready = (state==IDLE || state==RUN) && (!win_valid || s2_free).
  - On input accept at (row,col):
    - Each window row shifts left; new column = {lb1[col], lb0[col], in_pix}.
    - lb1[col] <= lb0[col]; lb0[col] <= in_pix.
    - win_valid <= (row>=2 && col>=2).
  - If there is no input accept but S1 moves into S2, win_valid <= 0.
  - S1->S2 when win_valid && s2_free: out_pix <= median_in, out_valid <= 1, out_last <= (S1 window centre is at row IMG_H-2, col IMG_W-2).
  - If s2_free and S1 is not moving, out_valid <= 0.
- Latency: input accepted at cycle N gives out_valid at N+2 with no backpressure. Throughput is 1 pixel/clk.
- Counters:
  - col increments per input accept; wraps to 0 at IMG_W-1 with row increment.
  - After pixel (IMG_H-1, IMG_W-1), both wrap to 0.
- State machine:
  - IDLE -> RUN on first input accept (busy=1).
  - RUN -> DRAIN on accept of pixel (IMG_H-1, IMG_W-1); in_ready=0 in DRAIN.
  - DRAIN -> IDLE on the output accept with out_last=1.
  - No back-to-back frame overlap: the next frame waits for DRAIN completion.
- Borders: rows 0-1 and cols 0-1 of each row produce no output, only buffering.
- Window contents are stale only while win_valid=0; w0..w8 are always driven from the registers.
- Backpressure: out_pix/out_valid/out_last are held stable while out_valid && !out_ready. Upstream stalls via in_ready with no pixel loss or duplication.
- Reset mid-frame: everything is aborted immediately, with no partial output; the next pixel starts a new frame at (0,0).

Optional Feature:
- Macro MEDIAN_BYPASS_EN.
- When defined:
  - Adds input bypass (1 bit). When bypass=1, S2 captures w4 (the centre pixel) instead of median_in.
  - bypass is sampled on the S1->S2 transfer; timing and handshakes are unchanged.
- When undefined: no bypass port; S2 always captures median_in.

Test Plan:
- IMG_W=4, IMG_H=4; ramp pixel=16*row+col; no backpressure -> outputs 17, 18, 33, 34; out_last only on 34; first out_valid 2 cycles after pixel (2,2) is accepted; busy falls after the last handshake.
- IMG_W=4, IMG_H=4; all pixels 10 except (1,1)=255 -> outputs 10, 10, 10, 10 (impulse removed).
- Ramp frame with out_ready toggled 1-cycle on/2-cycle off, plus in_valid gaps -> the same 4 values in order, out_pix held stable while stalled, in_ready=0 whenever S1 and S2 are both full.
- rst_n pulsed low after 7 pixels, then a full ramp frame -> out_valid=0 immediately; exactly 4 outputs 17, 18, 33, 34 from the new frame.
- Two consecutive frames -> in_ready=0 during DRAIN; second-frame outputs are correct and independent of first-frame line-buffer data.
- MEDIAN_BYPASS_EN, bypass=1, impulse frame -> outputs 255, 10, 10, 10 (centre pixels (1,1), (1,2), (2,1), (2,2)).
